// File: rtl/alu_mul_sequencer.sv
// Multi-cycle UMUL/UMULcc controller that drives the shared 32-bit ALU through 32 shift-add steps.
// Optional SIGNED_MUL_EN adds the is_signed input and a FIX state that negates the product for SMUL.
module alu_mul_sequencer #(
  parameter logic [5:0] ALU_ADDCC_OP = 6'b010000,
  parameter logic [5:0] ALU_IDLE_OP  = 6'b000000,
  parameter int         STEPS        = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        set_cc,
`ifdef SIGNED_MUL_EN
  input  logic        is_signed,
`endif
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo,
  output logic        icc_we,
  output logic        icc_n,
  output logic        icc_z
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

`ifdef SIGNED_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   acc_hi;
  logic [31:0]   acc_lo;
  logic [31:0]   mcand_r;
  logic          set_cc_r;
`ifdef SIGNED_MUL_EN
  logic          signed_r;
  logic          neg_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand_r  <= '0;
      set_cc_r <= 1'b0;
`ifdef SIGNED_MUL_EN
      signed_r <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_hi   <= '0;
            count    <= '0;
            set_cc_r <= set_cc;
`ifdef SIGNED_MUL_EN
            signed_r <= is_signed;
            // Signed operands run through the unsigned datapath as magnitudes.
            if (is_signed) begin
              mcand_r <= mcand[31] ? -mcand : mcand;
              acc_lo  <= mplier[31] ? -mplier : mplier;
              neg_r   <= mcand[31] ^ mplier[31];
            end else begin
              mcand_r <= mcand;
              acc_lo  <= mplier;
              neg_r   <= 1'b0;
            end
`else
            mcand_r  <= mcand;
            acc_lo   <= mplier;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          // The ALU carry becomes bit 31 so the 33-bit partial sum is never truncated.
          acc_hi <= {alu_c, alu_out[31:1]};
          acc_lo <= {alu_out[0], acc_lo[31:1]};
          count  <= count + CW'(1);
          if (count == LAST) begin
`ifdef SIGNED_MUL_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end
`ifdef SIGNED_MUL_EN
        FIX: begin
          if (signed_r && neg_r) begin
            {acc_hi, acc_lo} <= -{acc_hi, acc_lo};
          end
          state <= DONE;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic run;
  assign run = (state == RUN);

  assign alu_op  = run ? ALU_ADDCC_OP : ALU_IDLE_OP;
  assign alu_a   = run ? acc_hi : '0;
  assign alu_b   = (run && acc_lo[0]) ? mcand_r : '0;
  assign alu_cin = 1'b0;

`ifdef SIGNED_MUL_EN
  assign busy    = run || (state == FIX);
`else
  assign busy    = run;
`endif
  assign done    = (state == DONE);
  assign icc_we  = done && set_cc_r;
  assign prod_hi = acc_hi;
  assign prod_lo = acc_lo;
  assign icc_n   = acc_lo[31];
  assign icc_z   = (acc_lo == 32'd0);

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that reuses the shared 32-bit ALU to run SPARC UMUL/UMULcc as a 32-step shift-add multiply.
- Sits between decode/control and the ALU operand muxes. While busy it owns the ALU op/operand inputs; decode stalls the pipeline on `busy`.
- Produces a 64-bit product: high word to Y, low word to rd. Optionally produces icc N/Z for the cc variants.

Parameters:
- ALU_ADDCC_OP, 6'b010000, ALU op code driven during every multiply step (ADDcc, so the carry is captured).
- ALU_IDLE_OP, 6'b000000, ALU op code driven when not stepping (ADD of zeros).
- STEPS, 32, number of shift-add iterations; must equal the ALU data width.

Ports:
- clk, input, 1, system clock; rising-edge.
- reset, input, 1, synchronous, active-high; returns the block to IDLE.
- start, input, 1, request pulse; accepted only in IDLE.
- set_cc, input, 1, sampled with start; when 1, icc update is requested at completion.
- mcand, input, 32, multiplicand; sampled with start.
- mplier, input, 32, multiplier; sampled with start.
- alu_out, input, 32, ALU result.
- alu_c, input, 1, ALU carry flag.
- alu_op, output, 6, ALU Op3 drive.
- alu_a, output, 32, ALU Ain drive.
- alu_b, output, 32, ALU Bin drive.
- alu_cin, output, 1, ALU Cin drive; always 0.
- busy, output, 1, high in RUN (and FIX when compiled in).
- done, output, 1, one-cycle completion pulse.
- prod_hi, output, 32, product bits 63:32 (to Y).
- prod_lo, output, 32, product bits 31:0 (to rd).
- icc_we, output, 1, icc write strobe; equals done & latched set_cc.
- icc_n, output, 1, equals prod_lo[31].
- icc_z, output, 1, equals (prod_lo == 0).

Behaviour:
- Reset and sync:
  - Clock is `clk`. Reset is `reset`: one clock, synchronous, active-high.
  - Reset values: state=IDLE, count=0, acc_hi=0, acc_lo=0, mcand_r=0, set_cc_r=0.
  - Outputs under reset: busy=0, done=0, icc_we=0, prod_hi=prod_lo=0, alu_op=ALU_IDLE_OP, alu_a=alu_b=0, alu_cin=0.
  - Reset in any state, including mid-RUN, aborts the operation. No done pulse; product registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: mcand_r<=mcand, acc_lo<=mplier, acc_hi<=0, count<=0, set_cc_r<=set_cc. Go to RUN.
  - On start=0: stay in IDLE.
- RUN, one step per cycle:
  - ALU drive: alu_op=ALU_ADDCC_OP, alu_a=acc_hi, alu_b = acc_lo[0] ? mcand_r : 0.
  - Register update: acc_hi<={alu_c, alu_out[31:1]}, acc_lo<={alu_out[0], acc_lo[31:1]}, count<=count+1.
  - When count==STEPS-1, go to DONE after that step.
- DONE:
  - done=1 for exactly one cycle; icc_we=set_cc_r.
  - Next state IDLE unconditionally.
- Outputs outside RUN: alu_op=ALU_IDLE_OP, alu_a=alu_b=0.
- Product hold: prod_hi/prod_lo are direct views of acc_hi/acc_lo. They are valid in DONE and held through IDLE until the next accepted start.
- Latency: start high in cycle n → RUN in cycles n+1..n+32 → done high in cycle n+33. The next start can be accepted in cycle n+34.
- Busy window: busy=1 exactly in the 32 RUN cycles.
- start while busy or in DONE: ignored, with no side effect on registers.
- Arithmetic: acc_hi addition uses the ALU's 33-bit {C,Out}, so no overflow is lost. The final {acc_hi, acc_lo} is the exact unsigned 64-bit product.
- The block never depends on ALU V/N/Z flags.
- Operand changes on mcand/mplier after start has no effect on the operation in progress.

Optional Feature:
- Macro: SIGNED_MUL_EN.
- Defined:
  - Adds port `is_signed` (input, 1), sampled with start.
  - If is_signed: magnitudes of mcand/mplier are loaded, and neg_r <= mcand[31]^mplier[31].
  - Adds state FIX between RUN and DONE, always entered. In FIX, if is_signed & neg_r, {acc_hi,acc_lo} <= two's complement of the 64-bit value; otherwise it is held.
  - busy stays high in FIX. Latency becomes done in cycle n+34 for both signed and unsigned.
- Undefined:
  - No is_signed port and no FIX state. Unsigned only; latency n+33.

Test Plan:
- Reset, then start with mcand=3, mplier=5, set_cc=0 → busy high for 32 cycles, done in cycle n+33, prod_hi=0, prod_lo=0x0000000F, icc_we=0.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF, set_cc=1 → prod_hi=0xFFFFFFFE, prod_lo=0x00000001, icc_we=1, icc_n=0, icc_z=0.
- mcand=0x12345678, mplier=0, set_cc=1 → prod_hi=prod_lo=0, icc_z=1, icc_n=0. In every RUN cycle alu_b=0 and alu_op=6'b010000.
- Start 7×9, then re-pulse start with 2×2 at RUN cycle 10 → the second start is ignored; done once at n+33 with prod_lo=0x3F.
- Start 7×9, assert reset at RUN cycle 15 → next cycle: state IDLE, busy=0, prod=0, and done never pulses. A fresh start of 4×4 then yields 0x10.
- With SIGNED_MUL_EN: is_signed=1, mcand=0xFFFFFFFD (-3), mplier=5 → done at n+34, prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFF1.
